// File: rtl/seq_mon_pkg.sv
// Shared types and helpers for the sequence stream monitor.
package seq_mon_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    LOST    = 2'd2
  } state_t;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] count, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (count >= max_v) ? max_v : count + 32'd1;
  endfunction

endpackage

// File: rtl/seq_mon_sat_counter.sv
// Enable-driven saturating counter used for the monitor's error/wrap/loss statistics.
module seq_mon_sat_counter
  import seq_mon_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= W'(sat_inc(32'(count), W));
    end
  end

endmodule

// File: rtl/seq_stream_monitor.sv
// Checks an 8-bit counter stream for +STEP continuity with ACQUIRE/TRACK/LOST locking.
// Optional mismatch capture ports enabled by SEQ_STREAM_MONITOR_CAPTURE_EN.
module seq_stream_monitor
  import seq_mon_pkg::*;
#(
  parameter int unsigned STEP       = 1,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              resync,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  wrap_count,
  output logic [CNT_W-1:0]  loss_count
`ifdef SEQ_STREAM_MONITOR_CAPTURE_EN
  ,
  output logic [DATA_W-1:0] last_exp,
  output logic [DATA_W-1:0] last_got
`endif
);

  localparam int MR_W = $clog2(LOCK_COUNT + 1);
  localparam int MS_W = $clog2(LOSS_COUNT + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic [MR_W-1:0]   match_run_q, match_run_d;
  logic [MS_W-1:0]   miss_run_q, miss_run_d;

  logic [DATA_W-1:0] expected;
  logic              match;
  logic              err_d, wrap_inc, loss_inc, capture;

  assign expected = prev_q + DATA_W'(STEP);
  assign match    = have_prev_q && (in_data == expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACQUIRE;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      locked      <= (state_d == TRACK);
      err_pulse   <= err_d;
    end
  end

  // resync outranks a same-cycle sample: the sample is dropped entirely.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    err_d       = 1'b0;
    wrap_inc    = 1'b0;
    loss_inc    = 1'b0;
    capture     = 1'b0;
    if (resync) begin
      state_d     = ACQUIRE;
      have_prev_d = 1'b0;
      match_run_d = '0;
      miss_run_d  = '0;
    end else if (in_valid) begin
      prev_d      = in_data;
      have_prev_d = 1'b1;
      case (state_q)
        ACQUIRE: begin
          if (match) begin
            match_run_d = match_run_q + MR_W'(1);
            if (match_run_q == MR_W'(LOCK_COUNT - 1)) begin
              state_d    = TRACK;
              miss_run_d = '0;
            end
          end else begin
            match_run_d = '0;
          end
        end
        TRACK: begin
          if (match) begin
            miss_run_d = '0;
            wrap_inc   = (in_data < prev_q);
          end else begin
            err_d      = 1'b1;
            capture    = 1'b1;
            miss_run_d = miss_run_q + MS_W'(1);
            if (miss_run_q == MS_W'(LOSS_COUNT - 1)) begin
              state_d  = LOST;
              loss_inc = 1'b1;
            end
          end
        end
        LOST: begin
          state_d     = ACQUIRE;
          match_run_d = match ? MR_W'(1) : '0;
        end
        default: state_d = ACQUIRE;
      endcase
    end
  end

  seq_mon_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .en(err_d), .count(err_count)
  );

  seq_mon_sat_counter #(.W(CNT_W)) u_wrap_cnt (
    .clk(clk), .rst(rst), .en(wrap_inc), .count(wrap_count)
  );

  seq_mon_sat_counter #(.W(CNT_W)) u_loss_cnt (
    .clk(clk), .rst(rst), .en(loss_inc), .count(loss_count)
  );

`ifdef SEQ_STREAM_MONITOR_CAPTURE_EN
  // Holds the most recent TRACK mismatch; deliberately untouched by resync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_exp <= '0;
      last_got <= '0;
    end else if (capture) begin
      last_exp <= expected;
      last_got <= in_data;
    end
  end
`endif

endmodule

// File: tb/tb_seq_stream_monitor.sv
// Bench for seq_stream_monitor: directed scenarios plus random stream against a rule-level model.
module tb_seq_stream_monitor;

  localparam int STEP       = 1;
  localparam int LOCK_COUNT = 4;
  localparam int LOSS_COUNT = 2;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef SEQ_STREAM_MONITOR_CAPTURE_EN
  localparam int SNAP_W = 2 + 3 * CNT_W + 16;
`else
  localparam int SNAP_W = 2 + 3 * CNT_W;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'd0;
  logic             resync = 1'b0;
  logic             locked, err_pulse;
  logic [CNT_W-1:0] err_count, wrap_count, loss_count;
`ifdef SEQ_STREAM_MONITOR_CAPTURE_EN
  logic [7:0]       last_exp, last_got;
`endif

  seq_stream_monitor #(
    .STEP(STEP), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .resync(resync),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .wrap_count(wrap_count), .loss_count(loss_count)
`ifdef SEQ_STREAM_MONITOR_CAPTURE_EN
    , .last_exp(last_exp), .last_got(last_got)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  string m_mode = "acquire";
  int    m_prev = 0, m_have = 0, m_run = 0, m_miss = 0;
  int    m_err = 0, m_wrap = 0, m_loss = 0, m_pulse = 0;
  int    m_lexp = 0, m_lgot = 0;

  logic [SNAP_W-1:0] exp_q[$];
  logic [SNAP_W-1:0] want, got;

  function automatic int sat(input int c);
    return (c < CNT_MAX) ? c + 1 : CNT_MAX;
  endfunction

  function automatic logic [SNAP_W-1:0] model_snap();
    logic [SNAP_W-1:0] s;
    s = {(m_mode == "track") ? 1'b1 : 1'b0, m_pulse[0],
         CNT_W'(m_err), CNT_W'(m_wrap), CNT_W'(m_loss)
`ifdef SEQ_STREAM_MONITOR_CAPTURE_EN
         , 8'(m_lexp), 8'(m_lgot)
`endif
        };
    return s;
  endfunction

  task automatic model_reset();
    m_mode = "acquire"; m_prev = 0; m_have = 0; m_run = 0; m_miss = 0;
    m_err = 0; m_wrap = 0; m_loss = 0; m_pulse = 0; m_lexp = 0; m_lgot = 0;
  endtask

  task automatic model_sample(input logic v, input int d, input logic rs);
    int expv;
    bit hit;
    m_pulse = 0;
    if (rs) begin
      m_mode = "acquire"; m_have = 0; m_run = 0; m_miss = 0;
    end else if (v) begin
      expv = (m_prev + STEP) % 256;
      hit  = (m_have != 0) && (d == expv);
      if (m_mode == "acquire") begin
        m_run = hit ? m_run + 1 : 0;
        if (m_run >= LOCK_COUNT) begin m_mode = "track"; m_miss = 0; end
      end else if (m_mode == "track") begin
        if (hit) begin
          m_miss = 0;
          if (d < m_prev) m_wrap = sat(m_wrap);
        end else begin
          m_err = sat(m_err); m_pulse = 1; m_miss++;
          m_lexp = expv; m_lgot = d;
          if (m_miss >= LOSS_COUNT) begin m_mode = "lost"; m_loss = sat(m_loss); end
        end
      end else begin
        m_mode = "acquire";
        m_run  = hit ? 1 : 0;
      end
      m_prev = d; m_have = 1;
    end
  endtask

  // ---------------- checks ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: one expected snapshot per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      got  = {locked, err_pulse, err_count, wrap_count, loss_count
`ifdef SEQ_STREAM_MONITOR_CAPTURE_EN
              , last_exp, last_got
`endif
             };
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, got, want);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [7:0] d, input logic rs);
    in_valid = v; in_data = d; resync = rs;
    @(posedge clk);
    if (rst) model_reset();
    else model_sample(v, int'(d), rs);
    exp_q.push_back(model_snap());
    #1;
  endtask

  task automatic async_reset();
    #6;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_locked", locked, 0);
    chk("async_rst_err", err_count, 0);
    chk("async_rst_loss", loss_count, 0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] p, bd, last_d;
    int lexp_lit, lgot_lit;
    lexp_lit = 0; lgot_lit = 0;

    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    rst = 1'b0;
    chk("reset_locked", locked, 0);
    chk("reset_err_pulse", err_pulse, 0);
    chk("reset_counts", int'(err_count) + int'(wrap_count) + int'(loss_count), 0);

    // 0..4 acquires lock on the fifth sample
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'(k), 1'b0);
      if (k == 3) chk("not_locked_after_4", locked, 0);
    end
    chk("locked_after_5", locked, 1);
    chk("counts_after_lock", int'(err_count) + int'(wrap_count) + int'(loss_count), 0);

    // relock at 0xFE then cross the wrap
    step(1'b0, 8'd0, 1'b1);
    chk("resync_unlocks", locked, 0);
    for (int k = 8'hFA; k <= 8'hFF; k++) step(1'b1, 8'(k), 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    chk("wrap_count_1", wrap_count, 1);
    chk("wrap_no_err", err_count, 0);

    // single skip while tracking
    for (int k = 2; k <= 16; k++) step(1'b1, 8'(k), 1'b0);
    step(1'b1, 8'h12, 1'b0);
    chk("skip_err_pulse", err_pulse, 1);
    chk("skip_err_count", err_count, 1);
    step(1'b1, 8'h13, 1'b0);
    chk("skip_pulse_one_cycle", err_pulse, 0);
    chk("skip_still_locked", locked, 1);

    // two bad samples lose lock, then relock
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h30, 1'b0);
    chk("loss_err_count", err_count, 3);
    chk("loss_count_1", loss_count, 1);
    chk("loss_unlocked", locked, 0);
    for (int k = 8'h31; k <= 8'h35; k++) begin
      step(1'b1, 8'(k), 1'b0);
      if (k == 8'h33) chk("relock_pending", locked, 0);
    end
    chk("relocked", locked, 1);

    // resync with a coincident sample drops that sample
    step(1'b1, 8'h40, 1'b1);
    for (int k = 8'h41; k <= 8'h45; k++) begin
      step(1'b1, 8'(k), 1'b0);
      if (k == 8'h44) chk("resync_sample_dropped", locked, 0);
    end
    chk("resync_relock", locked, 1);
    chk("resync_keeps_err", err_count, 3);
    chk("resync_keeps_loss", loss_count, 1);

    // 20 isolated mismatches saturate err_count
    p = 8'h45;
    for (int j = 0; j < 20; j++) begin
      bd = p + 8'd3;
      step(1'b1, bd, 1'b0);
      lexp_lit = int'(p + 8'd1); lgot_lit = int'(bd);
      p = bd + 8'd1;
      step(1'b1, p, 1'b0);
    end
    chk("err_saturated", err_count, CNT_MAX);
    chk("sat_still_locked", locked, 1);
    chk("sat_loss_unchanged", loss_count, 1);
`ifdef SEQ_STREAM_MONITOR_CAPTURE_EN
    chk("last_exp_final", last_exp, lexp_lit);
    chk("last_got_final", last_got, lgot_lit);
`endif

    async_reset();

    // random stream
    last_d = 8'd0;
    for (int i = 0; i < 3000; i++) begin
      logic v, rs;
      logic [7:0] d;
      v  = ($urandom_range(0, 99) < 80);
      rs = ($urandom_range(0, 99) < 2);
      d  = ($urandom_range(0, 99) < 85) ? last_d + 8'(STEP) : 8'($urandom_range(0, 255));
      if (v) last_d = d;
      step(v, d, rs);
      if (i % 600 == 599) async_reset();
    end

    step(1'b0, 8'd0, 1'b0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
